ram_burst_reader: RTL and testbench

Sequential burst reader for the synchronous-read `DualPortRam`; the read-side counterpart to whatever fills that RAM through its write port. On a start command it walks `i_len` consecutive addresses from `i_baseAddr`, absorbs the RAM's one-cycle registered read latency, and presents the words in order on a valid/ready stream. A 2-entry output buffer lets it sustain one word per cycle under continuous `i_ready` while never dropping data under backpressure.

---
 rtl/ram_burst_reader.sv | 182 ++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads a run of consecutive words from a DualPortRam that
// has a one-cycle registered read. The words come out in address order on a
// valid/ready stream. A two-entry buffer absorbs the RAM latency. It sustains
// one word per cycle and never drops a word under backpressure.
//
// Stream handshake: a word transfers on a rising edge where o_valid and
// i_ready are both high. Once o_valid is raised, it stays high and o_data
// stays unchanged until that transfer happens. o_valid does not depend
// combinationally on i_ready.
module ram_burst_reader #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_baseAddr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rAddr,
  input  logic [XLEN-1:0]       i_q,
  output logic                  o_valid,
  output logic [XLEN-1:0]       o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_dbgState,
  output logic [1:0]            o_dbgCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  // Address currently presented to the RAM and reads still to be issued.
  logic [ADDR_WIDTH-1:0] rAddr;
  logic [ADDR_WIDTH:0]   remaining;
  // High for the one cycle in which the RAM output holds a word we asked for.
  logic                  inflight;
  logic                  done;

  // Two-entry buffer; buf0 is always the oldest word.
  logic [1:0]            count;
  logic [XLEN-1:0]       buf0;
  logic [XLEN-1:0]       buf1;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  startBurst;
  logic                  startEmpty;
  logic                  finish;
  logic [2:0]            occupancy;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode, read issue decision and stream outputs.
  always_comb begin
    stateNext  = state;
    startBurst = 1'b0;
    startEmpty = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    pop        = (count != 2'd0) && i_ready;
    push       = inflight;
    // Slots that are taken or promised: buffered words plus the word in flight.
    occupancy  = {1'b0, count} + {2'b00, inflight};

    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            startBurst = 1'b1;
            stateNext  = READ;
          end else begin
            startEmpty = 1'b1;
          end
        end
      end
      READ: begin
        // Issue only if the word can land without exceeding two slots, after
        // counting this cycle's pop.
        if ((remaining != '0) && (occupancy < (3'd2 + {2'b00, pop}))) begin
          issue = 1'b1;
          if (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The burst ends when the last buffered word leaves and nothing is in flight.
        if (!inflight && (count == 2'd1) && pop) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    o_busy     = (state != IDLE);
    o_done     = done;
    o_rAddr    = rAddr;
    o_valid    = (count != 2'd0);
    o_data     = buf0;
    o_dbgState = state;
    o_dbgCount = count;
  end

  // Address walk, remaining count, in-flight flag and done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rAddr     <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= startEmpty | finish;
      inflight <= issue;
      if (startBurst) begin
        rAddr     <= i_baseAddr;
        remaining <= i_len;
      end else if (issue) begin
        // Wraps naturally past the top of the address space.
        rAddr     <= rAddr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Output buffer: push from the RAM, pop to the consumer, and keep order
  // when both happen in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= 2'd0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            buf0 <= i_q;
          end else begin
            buf1 <= i_q;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          buf0  <= buf1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf0 <= i_q;
          end else begin
            buf0 <= buf1;
            buf1 <= i_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Buffered words plus the word in flight never exceed the two slots.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ({1'b0, count} + {2'b00, inflight}) <= 3'd2);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader. It includes a behavioural model of the
// synchronous-read RAM.
module tb_ram_burst_reader;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     len;
  logic            busy;
  logic            done;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] ram_q;
  logic            valid;
  logic [XLEN-1:0] data;
  logic            ready;
  logic [1:0]      dbg_state;
  logic [1:0]      dbg_count;

  logic [XLEN-1:0] ram_mem [32];

  int tests;
  int fails;

  // Burst observation, filled by run_burst.
  logic [XLEN-1:0] got_q[$];
  logic [XLEN-1:0] exp_q[$];
  logic [AW-1:0]   addr_q[$];
  int  first_valid;
  int  last_pop;
  int  done_cnt;
  int  done_cyc;
  int  gap_cnt;
  int  hold_err;
  int  max_count;
  bit  busy_seen;
  bit  valid_seen;
  bit  rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  ram_burst_reader #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_baseAddr (base_addr),
    .i_len      (len),
    .o_busy     (busy),
    .o_done     (done),
    .o_rAddr    (r_addr),
    .i_q        (ram_q),
    .o_valid    (valid),
    .o_data     (data),
    .i_ready    (ready),
    .o_dbgState (dbg_state),
    .o_dbgCount (dbg_count)
  );

  // Clock and the RAM model's one-cycle read port.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= ram_mem[r_addr];

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic build_exp(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_q.push_back(ram_mem[a]);
    end
  endtask

  // Driver and monitor. It is entered just after a negedge. Inputs are driven
  // and outputs are sampled on negedges.
  // mode 0: always ready. mode 1: ready pattern 1,0,0,1,0,1.
  // inject_cyc: raise a second start (base 20) on that cycle.
  // pop_limit: return right after scheduling that many pops.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                           input int inject_cyc, input int pop_limit, input int budget);
    logic            stalled_prev;
    logic [XLEN-1:0] stalled_data;
    got_q.delete();
    addr_q.delete();
    first_valid = -1; last_pop = -1; done_cnt = 0; done_cyc = -1;
    gap_cnt = 0; hold_err = 0; max_count = 0; busy_seen = 0; valid_seen = 0;
    stalled_prev = 1'b0; stalled_data = '0;
    start = 1'b1; base_addr = b; len = n;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == inject_cyc) begin
        start = 1'b1; base_addr = 5'd20; len = 6'd7;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (int'(dbg_count) > max_count) max_count = int'(dbg_count);
      if (busy && (addr_q.size() == 0 || addr_q[$] != r_addr)) addr_q.push_back(r_addr);
      if (stalled_prev && (!valid || data !== stalled_data)) hold_err++;
      ready = (mode == 1) ? rdy_pat[(cyc - 1) % 6] : 1'b1;
      if (valid) begin
        valid_seen = 1'b1;
        if (first_valid < 0) first_valid = cyc;
      end
      if (valid && ready) begin
        if (last_pop >= 0 && cyc != last_pop + 1) gap_cnt++;
        last_pop = cyc;
        got_q.push_back(data);
      end
      stalled_prev = valid && !ready;
      stalled_data = data;
      if (pop_limit > 0 && got_q.size() == pop_limit) break;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    tests++; if (r_addr !== 5'd0) begin fails++; $display("FAIL reset_raddr: got %0d expected 0", r_addr); end
    tests++; if (data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", data); end
    repeat (3) @(negedge clk);
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    run_burst(5'd0, 6'd10, 0, 0, 0, 60);
    build_exp(5'd0, 10);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL basic_data: idx %0d got %0d words (word %h) expected %0d words (word %h)", d, got_q.size(), (d >= 0) ? got_q[d] : 32'h0, exp_q.size(), (d >= 0) ? exp_q[d] : 32'h0); end
    tests++; if (first_valid != 3) begin fails++; $display("FAIL basic_latency: first valid at cycle %0d expected 3", first_valid); end
    tests++; if (gap_cnt != 0) begin fails++; $display("FAIL basic_gaps: got %0d expected 0", gap_cnt); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    tests++; if (done_cyc != last_pop + 1) begin fails++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_pop + 1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %0b expected 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    int d;
    bit addr_ok;
    run_burst(5'd30, 6'd4, 0, 0, 0, 40);
    build_exp(5'd30, 4);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL wrap_data: idx %0d got %0d words expected %0d words", d, got_q.size(), exp_q.size()); end
    addr_ok = (addr_q.size() >= 4) && addr_q[0] == 5'd30 && addr_q[1] == 5'd31 && addr_q[2] == 5'd0 && addr_q[3] == 5'd1;
    tests++; if (!addr_ok) begin fails++; $display("FAIL wrap_raddr: got %0d addresses starting %0d expected 30,31,0,1", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 5'd0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int d;
    run_burst(5'd10, 6'd6, 1, 0, 0, 80);
    build_exp(5'd10, 6);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL bp_data: idx %0d got %0d words expected %0d words", d, got_q.size(), exp_q.size()); end
    tests++; if (hold_err != 0) begin fails++; $display("FAIL bp_hold: got %0d stall violations expected 0", hold_err); end
    tests++; if (max_count > 2) begin fails++; $display("FAIL bp_count: got max %0d expected <= 2", max_count); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_and_busy();
    int d;
    run_burst(5'd3, 6'd0, 0, 0, 0, 10);
    tests++; if (done_cnt != 1 || done_cyc != 1) begin fails++; $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at cycle 1", done_cnt, done_cyc); end
    tests++; if (valid_seen) begin fails++; $display("FAIL zero_valid: got valid 1 expected 0"); end
    tests++; if (busy_seen) begin fails++; $display("FAIL zero_busy: got busy 1 expected 0"); end
    repeat (2) @(negedge clk);
    run_burst(5'd0, 6'd5, 0, 3, 0, 60);
    build_exp(5'd0, 5);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL busy_start_data: idx %0d got %0d words expected %0d words", d, got_q.size(), exp_q.size()); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL busy_start_idle: got busy %0b valid %0b expected 0 0", busy, valid); end
  endtask

  task automatic test_reset_mid();
    int d;
    bit saw_done;
    bit saw_valid;
    run_burst(5'd0, 6'd10, 0, 0, 3, 40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_flags: got busy %0b valid %0b done %0b expected 0 0 0", busy, valid, done); end
    tests++; if (r_addr !== 5'd0) begin fails++; $display("FAIL midrst_raddr: got %0d expected 0", r_addr); end
    tests++; if (data !== 32'h0) begin fails++; $display("FAIL midrst_data: got %h expected 0", data); end
    saw_done = 0; saw_valid = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (valid) saw_valid = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (valid) saw_valid = 1;
    end
    tests++; if (saw_done || saw_valid) begin fails++; $display("FAIL midrst_quiet: got done %0b valid %0b expected 0 0", saw_done, saw_valid); end
    run_burst(5'd0, 6'd2, 0, 0, 0, 30);
    exp_q.delete();
    exp_q.push_back(32'hdeadbeef);
    exp_q.push_back(32'h8badf00d);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL midrst_after_data: idx %0d got %0d words expected %0d words", d, got_q.size(), exp_q.size()); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL midrst_after_done: got %0d expected 1", done_cnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_length();
    int d;
    run_burst(5'd7, 6'd32, 0, 0, 0, 100);
    build_exp(5'd7, 32);
    d = first_diff();
    tests++; if (d != -1) begin fails++; $display("FAIL full_data: idx %0d got %0d words expected %0d words", d, got_q.size(), exp_q.size()); end
    tests++; if (gap_cnt != 0) begin fails++; $display("FAIL full_gaps: got %0d expected 0", gap_cnt); end
    tests++; if (done_cnt != 1 || done_cyc != last_pop + 1) begin fails++; $display("FAIL full_done: got %0d pulses at cycle %0d expected 1 at %0d", done_cnt, done_cyc, last_pop + 1); end
  endtask

  // Sequence of scenarios, followed by the report.
  initial begin
    tests = 0; fails = 0;
    start = 1'b0; base_addr = '0; len = '0; ready = 1'b1; rst_n = 1'b1;
    ram_mem[0] = 32'hdeadbeef; ram_mem[1] = 32'h8badf00d; ram_mem[2] = 32'h00c0ffee;
    ram_mem[3] = 32'hdeadc0de; ram_mem[4] = 32'hbadf000d; ram_mem[5] = 32'hdefac8ed;
    ram_mem[6] = 32'hcafebabe; ram_mem[7] = 32'hdeadd00d; ram_mem[8] = 32'hcafed00d;
    ram_mem[9] = 32'hdeadbabe;
    for (int i = 10; i < 32; i++) ram_mem[i] = 32'h5a000000 + 32'(i * 32'h00010101);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_busy();
    test_reset_mid();
    test_full_length();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
